// File: rtl/line_cache_sched_pkg.sv
// Shared widths, scheduler state encoding and the cache rotation helper
// for the line cache scheduler.
package line_cache_sched_pkg;

    localparam int PIX_W  = 8;
    localparam int ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2
    } sched_state_t;

    // Cache holding row y-k when row y is being written into cache wsel.
    function automatic int unsigned tap_sel(input int unsigned wsel,
                                            input int unsigned k,
                                            input int unsigned taps);
        return (wsel + taps - k) % taps;
    endfunction

endpackage

// File: rtl/line_cache.sv
// One raster line of pixel storage: independent write port and a
// registered read port (data valid the cycle after the address).
module line_cache #(
    parameter int DEPTH = 640,
    parameter int AW    = 10,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_r [DEPTH];

    // Pixel write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port; the caller holds the address to keep data stable
    always_ff @(posedge clk) begin
        rd_data <= mem_r[rd_addr];
    end

endmodule

// File: rtl/line_cache_scheduler.sv
// Turns a raster pixel stream into TAPS-tall vertical columns by writing and
// reading a bank of line caches in rotation.
module line_cache_scheduler
    import line_cache_sched_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int TAPS   = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sof,
    input  logic [PIX_W-1:0]        in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PIX_W*TAPS-1:0]   out_col,
    output logic [ADDR_W-1:0]       out_x,
    output logic [ADDR_W-1:0]       out_y
);

    localparam int SEL_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int CA_W  = $clog2(WIDTH);
    localparam logic [ADDR_W-1:0] X_LAST       = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] Y_LAST       = ADDR_W'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] Y_PRIME_LAST = ADDR_W'(TAPS - 2);
    localparam logic [SEL_W-1:0]  SEL_LAST     = SEL_W'(TAPS - 1);

    sched_state_t        state_r;
    sched_state_t        base_state_s;
    sched_state_t        nstate_s;
    logic [ADDR_W-1:0]   x_r;
    logic [ADDR_W-1:0]   y_r;
    logic [SEL_W-1:0]    wsel_r;
    logic                run_r;
    logic [ADDR_W-1:0]   rd_addr_r;

    logic                accept_s;
    logic                stream_s;
    logic [ADDR_W-1:0]   px_s;
    logic [ADDR_W-1:0]   py_s;
    logic [SEL_W-1:0]    pw_s;
    logic [ADDR_W-1:0]   nx_s;
    logic [ADDR_W-1:0]   ny_s;
    logic [SEL_W-1:0]    nw_s;
    logic [ADDR_W-1:0]   rd_addr_s;
    logic [TAPS-1:0]     we_s;
    logic [PIX_W-1:0]    rd_data_s [TAPS];
    logic [PIX_W*TAPS-1:0] col_s;

    // Stage between cache read and output: live byte registered alongside cache data
    logic                s1_valid_r;
    logic [PIX_W-1:0]    s1_live_r;
    logic [SEL_W-1:0]    s1_sel_r;
    logic [ADDR_W-1:0]   s1_x_r;
    logic [ADDR_W-1:0]   s1_y_r;

    assign in_ready  = run_r & (~out_valid | out_ready);
    assign accept_s  = in_valid & in_ready;
    assign px_s      = in_sof ? '0 : x_r;
    assign py_s      = in_sof ? '0 : y_r;
    assign pw_s      = in_sof ? '0 : wsel_r;
    assign stream_s  = (state_r == STREAM) && !in_sof;
    assign rd_addr_s = accept_s ? px_s : rd_addr_r;

    // Next raster position, cache rotation and scheduler state for an accepted pixel
    always_comb begin
        base_state_s = ((state_r == IDLE) || in_sof) ? PRIME : state_r;
        nx_s         = px_s + ADDR_W'(1);
        ny_s         = py_s;
        nw_s         = pw_s;
        nstate_s     = base_state_s;
        if (px_s == X_LAST) begin
            nx_s = '0;
            if (py_s == Y_LAST) begin
                ny_s     = '0;
                nw_s     = '0;
                nstate_s = IDLE;
            end else begin
                ny_s = py_s + ADDR_W'(1);
                nw_s = (pw_s == SEL_LAST) ? '0 : pw_s + SEL_W'(1);
                if (py_s == Y_PRIME_LAST) begin
                    nstate_s = STREAM;
                end else begin
                    nstate_s = base_state_s;
                end
            end
        end else begin
            nx_s = px_s + ADDR_W'(1);
        end
    end

    // Column assembly: live pixel at the bottom, older rows from rotated caches
    always_comb begin
        col_s = '0;
        col_s[PIX_W-1:0] = s1_live_r;
        for (int k = 1; k < TAPS; k++) begin
            col_s[k*PIX_W +: PIX_W] =
                rd_data_s[SEL_W'(tap_sel(32'(s1_sel_r), 32'(k), 32'(TAPS)))];
        end
    end

    for (genvar g = 0; g < TAPS; g++) begin : g_cache
        assign we_s[g] = accept_s && (pw_s == SEL_W'(g));

        line_cache #(
            .DEPTH (WIDTH),
            .AW    (CA_W),
            .DW    (PIX_W)
        ) u_cache (
            .clk     (clk),
            .wr_en   (we_s[g]),
            .wr_addr (px_s[CA_W-1:0]),
            .wr_data (in_data),
            .rd_addr (rd_addr_s[CA_W-1:0]),
            .rd_data (rd_data_s[g])
        );
    end

    // Scheduler FSM, counters, read-address hold and the two-stage output pipeline
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= IDLE;
            x_r        <= '0;
            y_r        <= '0;
            wsel_r     <= '0;
            run_r      <= 1'b0;
            rd_addr_r  <= '0;
            s1_valid_r <= 1'b0;
            s1_live_r  <= '0;
            s1_sel_r   <= '0;
            s1_x_r     <= '0;
            s1_y_r     <= '0;
            out_valid  <= 1'b0;
            out_col    <= '0;
            out_x      <= '0;
            out_y      <= '0;
        end else begin
            run_r     <= 1'b1;
            rd_addr_r <= rd_addr_s;
            if (accept_s) begin
                x_r     <= nx_s;
                y_r     <= ny_s;
                wsel_r  <= nw_s;
                state_r <= nstate_s;
            end
            if (in_ready) begin
                s1_valid_r <= accept_s && stream_s;
                if (accept_s) begin
                    s1_live_r <= in_data;
                    s1_sel_r  <= pw_s;
                    s1_x_r    <= px_s;
                    s1_y_r    <= py_s;
                end
                out_valid <= s1_valid_r;
                if (s1_valid_r) begin
                    out_col <= col_s;
                    out_x   <= s1_x_r;
                    out_y   <= s1_y_r;
                end
            end
        end
    end

endmodule

// File: doc/line_cache_scheduler.md
# line_cache_scheduler

Sequences a bank of `line_cache` instances so an 8-bit raster pixel stream becomes a stream of vertical pixel columns, TAPS pixels tall. It sits between the camera/pixel source and the window/feature stages. Caches are written and read in rotation, so each accepted pixel yields the pixel column ending at it, with the live pixel at the bottom. Valid/ready handshaking is used on both sides.

## Interface
- WIDTH, 640: pixels per line.
- HEIGHT, 480: lines per frame.
- TAPS, 3: column height; also the number of `line_cache` instances.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low.
- in_valid  in  1  pixel offered.
- in_ready  out  1  pixel accepted when in_valid & in_ready.
- in_sof  in  1  start of frame; qualified by in_valid.
- in_data  in  8  pixel.
- out_valid  out  1  column valid.
- out_ready  in  1  consumer accepts column.
- out_col  out  8*TAPS  column: [7:0] = row y (live), [15:8] = row y-1, ..., top byte = row y-(TAPS-1).
- out_x  out  10  column x.
- out_y  out  10  column y.

## Operation
- States:
  - IDLE: no frame in progress.
  - PRIME: rows 0..TAPS-2; pixels are written, no output.
  - STREAM: y ≥ TAPS-1; output is produced.
- Counters:
  - x: 10-bit, wraps at WIDTH-1 to 0 and increments y.
  - y: 10-bit.
  - wsel: 0..TAPS-1; increments modulo TAPS on every x wrap.
- Per accepted pixel:
  - Write in_data to cache[wsel] at address x.
  - Drive read address x to all caches.
  - Row y-k is read from cache[(wsel-k) mod TAPS], k = 1..TAPS-1.
- Transitions:
  - IDLE→PRIME on first accepted pixel.
  - PRIME→STREAM on x wrap when y = TAPS-2.
  - STREAM→IDLE on acceptance of (WIDTH-1, HEIGHT-1); x, y and wsel are cleared.
  - IDLE is never entered as a stall. The pixel after a frame end is (0,0).
- in_sof accepted in any state:
  - That pixel is treated as (0,0); wsel is cleared; state becomes PRIME.
  - Cache contents are ignored, not cleared.
- Backpressure:
  - in_ready = !out_valid | out_ready.
  - While stalled, the last read address is held so the registered cache outputs stay stable.
- Bubbles (in_valid=0): no counter, state or cache change.
- Reset (reset=0):
  - state IDLE; x = y = wsel = 0.
  - out_valid = 0, in_ready = 0, out_col = 0, out_x = out_y = 0.
  - Cache contents are undefined; PRIME refills them before use.

## Timing
- `line_cache` read data is registered: valid one cycle after the address.
- Latency: a pixel accepted at edge t gives out_valid=1 after edge t+1, carrying that pixel's column.
- The live byte is registered alongside the cache read so all bytes align.
- out_valid rises only for pixels accepted with y ≥ TAPS-1. It clears on out_ready unless a new STREAM pixel is accepted in the same cycle.
- Full throughput: one column per cycle with in_valid = out_ready = 1.
- Write and read in the same cycle never target the same cache.
- Reset mid-operation: outputs take their reset values after the next edge. A column in flight is dropped.

## Structure
- Package `line_cache_sched_pkg` holds:
  - PIX_W = 8 and ADDR_W = 10.
  - State enum {IDLE, PRIME, STREAM}.
  - Helper function for (wsel-k) mod TAPS.
- Sub-module: the existing `line_cache`, instantiated TAPS times via generate.
- Mapping of the shared read address and per-cache write enables:
  - Each cache's write enable is one-hot from wsel and gated by acceptance.
  - All caches share write_addr = x and read address = x.
- The counter/FSM and the column mux stay in this module.

## Test plan
All tests use WIDTH=8, HEIGHT=6, TAPS=3, and a ramp in_data = y*16 + x.
- Ramp from reset, out_ready=1. No out_valid for rows 0-1. Pixel (0,2) → next cycle out_valid=1, out_col=24'h001020, out_x=0, out_y=2.
- out_ready=0 for 3 cycles at (3,3) → in_ready=0, out_col held at 24'h132333, no pixel lost; next column (4,3)=24'h142434.
- Last pixel (7,5) accepted, then continue the ramp → no out_valid until (0,2) of the next frame; that column is again 24'h001020.
- in_sof with data 8'h00 at position (4,3) → counters resync to (0,0), no out_valid for the next 16 accepted pixels.
- reset=0 for one cycle mid-row in STREAM → out_valid=0 and in_ready=0 after the edge; restart priming from (0,0).
- Random in_valid bubbles and out_ready gaps over 2 frames → output sequence matches a golden column model exactly.
